// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family.
// No logic; elaboration-time only.
// No flow control of its own.
package fifo_pkg;

  // Read-mode selector for the FWFT parameter.
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Ceiling log2 for sizing counters and addresses in FIFO variants.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write port, synchronous registered read port.
// Latency: write visible to a read on the following edge; read data valid one edge after re.
// No backpressure; the controller guarantees no same-address read/write in one cycle.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [DEPTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int WORDS = 1 << DEPTH;

  logic [WIDTH-1:0] mem [WORDS];

  // Storage array is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register doubles as the FIFO's q, so it is reset and holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with registered flags, sticky errors and optional FWFT read.
// Latency: standard mode q one edge after pop; FWFT mode q one edge after the word reaches RAM.
// Backpressure: push ignored while full (sets overflow), pop ignored while empty (sets underflow).
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int WIDTH              = 8,
  parameter int DEPTH              = 6,
  parameter int ALMOST_EMPTY_COUNT = 1,
  parameter int ALMOST_FULL_COUNT  = 1,
  parameter int FWFT               = FWFT_OFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] d,
  input  logic             pop,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = DEPTH + 1;
  localparam logic [DEPTH:0] CAP   = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] AE_TH = CW'(ALMOST_EMPTY_COUNT);
  localparam logic [DEPTH:0] AF_TH = CAP - CW'(ALMOST_FULL_COUNT);

  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic             push_acc;
  logic             pop_acc;
  logic             ram_we;
  logic             ram_re;
  logic             valid_next;
  logic             mem_has_word;
  logic [DEPTH:0]   count_next;

  // Accept/read decisions and next occupancy.
  // In FWFT mode count includes the word sitting in q, so the RAM holds count - valid
  // words. A pop there acknowledges the presented word, so it is only taken while q is
  // live; during the one-cycle prefetch gap after a push into an empty FIFO a pop is
  // neither consumed nor flagged as an error.
  always_comb begin
    push_acc     = push && !full;
    mem_has_word = count > {{DEPTH{1'b0}}, valid};
    pop_acc      = 1'b0;
    ram_re       = 1'b0;
    valid_next   = 1'b0;
    if (FWFT == FWFT_ON) begin
      pop_acc    = pop && valid;
      ram_re     = (!valid || pop_acc) && mem_has_word;
      valid_next = ram_re || (valid && !pop_acc);
    end else begin
      pop_acc    = pop && !empty;
      ram_re     = pop_acc;
      valid_next = pop_acc;
    end
    count_next = count;
    if (push_acc && !pop_acc) begin
      count_next = count + CW'(1);
    end else if (!push_acc && pop_acc) begin
      count_next = count - CW'(1);
    end
  end

  // Reset takes priority over a push landing in the array on the same edge.
  assign ram_we = push_acc && !rst;

  // Pointers, occupancy and all status flags, registered from next-state count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      valid        <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + DEPTH'(1);
      end
      if (ram_re) begin
        rd_ptr <= rd_ptr + DEPTH'(1);
      end
      count        <= count_next;
      valid        <= valid_next;
      full         <= (count_next == CAP);
      empty        <= (count_next == '0);
      almost_empty <= (count_next <= AE_TH);
      almost_full  <= (count_next >= AF_TH);
      overflow     <= overflow | (push && full);
      underflow    <= underflow | (pop && empty);
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (d),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (q)
  );

endmodule
